// File: rtl/ub_pkg.sv
// Shared definitions for the unified-buffer arbiter: FSM state encoding,
// compute burst length and byte/word widths.
package ub_pkg;

    localparam int COMPUTE_WORDS = 16;
    localparam int BYTE_W        = 8;
    localparam int WORD_W        = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        H_LO   = 3'd1,
        H_LO_W = 3'd2,
        H_HI   = 3'd3,
        H_HI_W = 3'd4,
        C_OP   = 3'd5,
        C_W    = 3'd6,
        RSP    = 3'd7
    } ub_state_e;

endpackage

// File: rtl/ub_rr_arbiter.sv
// Two-way round-robin grant between host and compute requesters.
// Only compiled in when UB_ARB_RR_EN is defined; the fixed-priority build
// does not need this module at all.
`ifdef UB_ARB_RR_EN
module ub_rr_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic req_host,
    input  logic req_comp,
    input  logic advance,
    output logic gnt_host,
    output logic gnt_comp
);

    // 0: host preferred next, 1: compute preferred next
    logic ptr_r;

    // Grant the preferred requester when both ask, otherwise whoever asks
    always_comb begin
        gnt_host = req_host && (!req_comp || !ptr_r);
        gnt_comp = req_comp && (!req_host ||  ptr_r);
    end

    // Pointer flips to the requester that did not win the accepted grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 1'b0;
        end else if (advance) begin
            ptr_r <= gnt_host;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule
`endif

// File: rtl/ub_arbiter.sv
// Arbiter between a 16-bit host port and a wide compute port sharing one
// unified buffer. Host words are moved as two byte accesses (LO then HI)
// that are never split by a compute access.
// Optional feature macro: UB_ARB_RR_EN selects round-robin arbitration;
// without it compute has fixed priority over host.
module ub_arbiter
    import ub_pkg::*;
#(
    parameter int BUFFER_SIZE   = 1024,
    parameter int ADDRESS_SIZE  = $clog2(BUFFER_SIZE),
    parameter int COMPUTE_WORDS = ub_pkg::COMPUTE_WORDS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    host_req_valid,
    output logic                    host_req_ready,
    input  logic                    host_req_write,
    input  logic [ADDRESS_SIZE-1:0] host_req_addr,
    input  logic [15:0]             host_req_wdata,
    output logic                    host_rsp_valid,
    output logic [15:0]             host_rsp_rdata,
    input  logic                    comp_req_valid,
    output logic                    comp_req_ready,
    input  logic                    comp_req_write,
    input  logic [ADDRESS_SIZE-1:0] comp_req_addr,
    output logic                    comp_rsp_valid,
    output logic                    comp_rsp_err,
    output logic                    ub_we,
    output logic                    ub_re,
    output logic                    ub_compute_en,
    output logic                    ub_fifo_en,
    output logic                    ub_section,
    output logic [ADDRESS_SIZE-1:0] ub_address,
    output logic [7:0]              ub_fifo_in,
    input  logic [7:0]              ub_fifo_out,
    input  logic                    ub_done
);

    ub_state_e               state_r;
    ub_state_e               state_s;
    logic                    idle_s;
    logic                    gnt_host_s;
    logic                    gnt_comp_s;
    logic                    host_fire_s;
    logic                    comp_fire_s;
    logic                    comp_range_err_s;
    logic                    cur_host_r;
    logic                    wr_r;
    logic                    err_r;
    logic [ADDRESS_SIZE-1:0] addr_r;
    logic [WORD_W-1:0]       wdata_r;
    logic [BYTE_W-1:0]       lo_byte_r;
    logic [WORD_W-1:0]       rdata_r;

    assign idle_s = (state_r == IDLE);

`ifdef UB_ARB_RR_EN
    ub_rr_arbiter u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_host (host_req_valid),
        .req_comp (comp_req_valid),
        .advance  (host_fire_s || comp_fire_s),
        .gnt_host (gnt_host_s),
        .gnt_comp (gnt_comp_s)
    );
`else
    // Fixed priority: compute always wins a tie
    always_comb begin
        gnt_comp_s = comp_req_valid;
        gnt_host_s = host_req_valid && !comp_req_valid;
    end
`endif

    // Ready only reaches the granted requester, and only while idle
    assign host_req_ready = idle_s && gnt_host_s;
    assign comp_req_ready = idle_s && gnt_comp_s;
    assign host_fire_s    = host_req_valid && host_req_ready;
    assign comp_fire_s    = comp_req_valid && comp_req_ready;

    // Compute burst must fit entirely inside the buffer
    assign comp_range_err_s = (32'(comp_req_addr) + 32'(COMPUTE_WORDS)) > 32'(BUFFER_SIZE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; ub_done only matters in the wait states
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (host_fire_s) begin
                    state_s = H_LO;
                end else if (comp_fire_s) begin
                    state_s = comp_range_err_s ? RSP : C_OP;
                end else begin
                    state_s = IDLE;
                end
            end
            H_LO:    state_s = H_LO_W;
            H_LO_W:  state_s = ub_done ? H_HI : H_LO_W;
            H_HI:    state_s = H_HI_W;
            H_HI_W:  state_s = ub_done ? RSP : H_HI_W;
            C_OP:    state_s = C_W;
            C_W:     state_s = ub_done ? RSP : C_W;
            RSP:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Request capture and read-data assembly; host_rsp_rdata only changes
    // when a complete host read finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_host_r <= 1'b0;
            wr_r       <= 1'b0;
            err_r      <= 1'b0;
            addr_r     <= {ADDRESS_SIZE{1'b0}};
            wdata_r    <= 16'h0000;
            lo_byte_r  <= 8'h00;
            rdata_r    <= 16'h0000;
        end else begin
            if (host_fire_s) begin
                cur_host_r <= 1'b1;
                wr_r       <= host_req_write;
                err_r      <= 1'b0;
                addr_r     <= host_req_addr;
                wdata_r    <= host_req_wdata;
            end else if (comp_fire_s) begin
                cur_host_r <= 1'b0;
                wr_r       <= comp_req_write;
                err_r      <= comp_range_err_s;
                addr_r     <= comp_req_addr;
            end
            if ((state_r == H_LO_W) && ub_done && !wr_r) begin
                lo_byte_r <= ub_fifo_out;
            end
            if ((state_r == H_HI_W) && ub_done && !wr_r) begin
                rdata_r <= {ub_fifo_out, lo_byte_r};
            end
        end
    end

    assign host_rsp_rdata = rdata_r;

    // Moore outputs: each strobe state lasts one cycle, waits drive nothing
    always_comb begin
        ub_we          = 1'b0;
        ub_re          = 1'b0;
        ub_compute_en  = 1'b0;
        ub_fifo_en     = 1'b0;
        ub_section     = 1'b0;
        ub_address     = {ADDRESS_SIZE{1'b0}};
        ub_fifo_in     = 8'h00;
        host_rsp_valid = 1'b0;
        comp_rsp_valid = 1'b0;
        comp_rsp_err   = 1'b0;
        case (state_r)
            H_LO: begin
                ub_fifo_en = 1'b1;
                ub_we      = wr_r;
                ub_re      = !wr_r;
                ub_address = addr_r;
                ub_fifo_in = wdata_r[7:0];
            end
            H_HI: begin
                ub_fifo_en = 1'b1;
                ub_section = 1'b1;
                ub_we      = wr_r;
                ub_re      = !wr_r;
                ub_address = addr_r;
                ub_fifo_in = wdata_r[15:8];
            end
            C_OP: begin
                ub_compute_en = 1'b1;
                ub_we         = wr_r;
                ub_re         = !wr_r;
                ub_address    = addr_r;
            end
            RSP: begin
                host_rsp_valid = cur_host_r;
                comp_rsp_valid = !cur_host_r;
                comp_rsp_err   = !cur_host_r && err_r;
            end
            default: begin
                ub_we = 1'b0;
            end
        endcase
    end

endmodule
